csr_file: RTL
=============

Name: csr_file

Overview:
- Machine-mode CSR responder that executes the csr_rd / csr_wr / is_mret requests raised by the instruction decoder.
- Holds the CSR state, arbitrates timer and external interrupts, and supplies the PC redirect target on trap entry and on mret.
- Sits beside the register file in the memory/writeback stage; csr_rdata feeds the writeback mux on wb_sel = 2'b11.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- MEPC_RST, 32'h0000_0000, reset value of mepc.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- csr_rd  input  1  read request from the decoder.
- csr_wr  input  1  write request from the decoder.
- is_mret  input  1  mret request from the decoder.
- csr_addr  input  12  CSR address (instr[31:20]).
- csr_wdata  input  32  write data (rs1 value).
- pc  input  32  PC of the instruction in this stage.
- pc_valid  input  1  instruction in this stage is valid (not a bubble or flushed).
- timer_irq  input  1  level-sensitive timer interrupt.
- ext_irq  input  1  level-sensitive external interrupt.
- csr_rdata  output  32  read data, combinational.
- epc_taken  output  1  redirect PC this cycle, combinational.
- epc  output  32  redirect target, valid when epc_taken = 1.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE (bit 3) and MPIE (bit 7) are stored; all other bits read 0.
  - mie 0x304: only MTIE (bit 7) and MEIE (bit 11) are stored.
  - mtvec 0x305: full 32 bits; bits [1:0] select the mode, 00 = direct, 01 = vectored.
  - mepc 0x341: bits [1:0] are forced to 0 on every write.
  - mcause 0x342: full 32 bits.
  - mip 0x344: read-only; bit 7 = timer_irq, bit 11 = ext_irq, sampled live.
  - mcycle 0xB00 / mcycleh 0xB80: 64-bit cycle counter.
- Reset (asynchronous, rst_n = 0):
  - mstatus = 0, mie = 0, mcause = 0, mcycle = 0.
  - mtvec = MTVEC_RST, mepc = MEPC_RST.
  - Outputs settle to csr_rdata = 0 and epc_taken = 0 while the request inputs are 0.
  - Reset asserted mid-operation discards any pending trap.
- Reads:
  - When csr_rd = 1, csr_rdata = value at csr_addr in the same cycle; otherwise csr_rdata = 0.
  - An unimplemented address reads 0.
- Writes:
  - When csr_wr = 1 and pc_valid = 1, the CSR at csr_addr is written at the clock edge with WARL masking as listed above.
  - Writes to mip or to an unimplemented address are ignored.
  - csr_rd and csr_wr asserted together return the old value in that cycle, and the new value from the next cycle.
- mcycle:
  - Increments by 1 every cycle and wraps from 2^64-1 to 0.
  - A write to 0xB00 or 0xB80 replaces that half with the written value; the increment resumes on the next cycle (no +1 in the write cycle).
- Interrupt request:
  - irq_pend = mstatus.MIE & pc_valid & ((ext_irq & MEIE) | (timer_irq & MTIE)).
  - External has priority: cause 32'h8000_000B; timer cause is 32'h8000_0007.
- Trap entry (irq_pend = 1 and is_mret = 0), same cycle:
  - epc_taken = 1.
  - epc = mtvec base (mtvec with bits [1:0] zeroed) in direct mode.
  - epc = base + 4*(cause[3:0]) in vectored mode.
- Trap entry, at the clock edge:
  - mepc <= pc, mcause <= cause.
  - MPIE <= MIE, MIE <= 0.
  - Any csr_wr in the same cycle is dropped, because the instruction is flushed.
- mret (is_mret = 1 and pc_valid = 1), same cycle:
  - epc_taken = 1, epc = mepc.
- mret, at the clock edge:
  - MIE <= MPIE, MPIE <= 1.
- mret wins over a simultaneous interrupt; the interrupt re-evaluates on the next cycle with the restored MIE.
- Interrupts are level-sensitive and not latched. Once MIE is cleared by trap entry, no further trap fires until software restores MIE.
- pc_valid = 0 blocks writes, mret and interrupts; reads stay combinational.

Test Plan:
- Reset then read: release rst_n, read 0x300 and 0x305 -> csr_rdata = 0 and MTVEC_RST; mcycle reads 5 after 5 cycles.
- Write masking: write 32'hFFFF_FFFF to 0x300, 0x304 and 0x341 -> reads return 32'h0000_0088, 32'h0000_0880 and 32'hFFFF_FFFC.
- Direct-mode timer trap:
  - Stimulus: mtvec = 0x100, mie = 0x80, mstatus = 0x8; raise timer_irq with pc = 0x40.
  - Same cycle: epc_taken = 1, epc = 0x100.
  - Next cycle: mepc = 0x40, mcause = 0x8000_0007, mstatus = 0x80.
- Vectored mode and priority:
  - Stimulus: mtvec = 0x201, both irqs enabled and raised together.
  - Response: epc = 0x22C, mcause = 0x8000_000B.
- mret against a pending irq:
  - Stimulus: after the trap, mret with ext_irq still high.
  - Response: epc = mepc in that cycle and mstatus = 0x88 after the edge; the trap fires again the next cycle.
- Trap beats write, and bubble gating:
  - Stimulus: csr_wr to 0x342 in the trap cycle.
  - Response: mcause holds the trap cause, not the written data.
  - Repeat with pc_valid = 0: no write, no trap.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR responder.
// Holds mstatus/mie/mtvec/mepc/mcause/mip/mcycle, arbitrates timer and
// external interrupts and supplies the PC redirect target on trap entry
// and on mret.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   csr_rd/csr_wr/is_mret decoder requests
//   csr_addr, csr_wdata   CSR address and write data (rs1)
//   pc, pc_valid          PC of the instruction in this stage, valid flag
//   timer_irq, ext_irq    level-sensitive interrupt lines
//   csr_rdata             combinational read data (0 when csr_rd = 0)
//   epc_taken, epc        combinational PC redirect request and target
module csr_file #(
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
   parameter logic [31:0] MEPC_RST  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_rd,
   input  logic        csr_wr,
   input  logic        is_mret,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic [31:0] pc,
   input  logic        pc_valid,
   input  logic        timer_irq,
   input  logic        ext_irq,
   output logic [31:0] csr_rdata,
   output logic        epc_taken,
   output logic [31:0] epc
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MIP     = 12'h344;
   localparam logic [11:0] A_MCYCLE  = 12'hB00;
   localparam logic [11:0] A_MCYCLEH = 12'hB80;

   localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
   localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

   logic        st_mie, st_mpie;
   logic        ie_mtie, ie_meie;
   logic [31:0] mtvec, mepc, mcause;
   logic [63:0] mcycle;

   logic        ext_hit, tmr_hit, irq_pend;
   logic        trap_go, mret_go, wr_go;
   logic [31:0] cause, base, vec_tgt;

   // ---------------- interrupt arbitration / redirect ----------------
   assign ext_hit  = ext_irq & ie_meie;
   assign tmr_hit  = timer_irq & ie_mtie;
   assign irq_pend = st_mie & pc_valid & (ext_hit | tmr_hit);
   assign cause    = ext_hit ? CAUSE_EXT : CAUSE_TMR;

   assign mret_go  = is_mret & pc_valid;
   // mret wins; the interrupt is re-evaluated next cycle with restored MIE.
   assign trap_go  = irq_pend & ~is_mret;
   // The trapped instruction is flushed, so its CSR write must not land.
   assign wr_go    = csr_wr & pc_valid & ~trap_go;

   assign base     = {mtvec[31:2], 2'b00};
   assign vec_tgt  = base + {26'd0, cause[3:0], 2'b00};

   assign epc_taken = trap_go | mret_go;
   assign epc       = mret_go ? mepc :
                      (mtvec[1:0] == 2'b01) ? vec_tgt : base;

   // ---------------- read mux ----------------
   always_comb begin
      csr_rdata = 32'd0;
      if (csr_rd) begin
         case (csr_addr)
            A_MSTATUS: csr_rdata = {24'd0, st_mpie, 3'd0, st_mie, 3'd0};
            A_MIE:     csr_rdata = {20'd0, ie_meie, 3'd0, ie_mtie, 7'd0};
            A_MTVEC:   csr_rdata = mtvec;
            A_MEPC:    csr_rdata = mepc;
            A_MCAUSE:  csr_rdata = mcause;
            A_MIP:     csr_rdata = {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};
            A_MCYCLE:  csr_rdata = mcycle[31:0];
            A_MCYCLEH: csr_rdata = mcycle[63:32];
            default:   csr_rdata = 32'd0;
         endcase
      end
   end

   // ---------------- CSR state ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_mie  <= 1'b0;
         st_mpie <= 1'b0;
         ie_mtie <= 1'b0;
         ie_meie <= 1'b0;
         mtvec   <= MTVEC_RST;
         mepc    <= MEPC_RST;
         mcause  <= 32'd0;
      end else if (trap_go) begin
         mepc    <= pc;
         mcause  <= cause;
         st_mpie <= st_mie;
         st_mie  <= 1'b0;
      end else begin
         if (wr_go) begin
            case (csr_addr)
               A_MSTATUS: begin
                  st_mie  <= csr_wdata[3];
                  st_mpie <= csr_wdata[7];
               end
               A_MIE: begin
                  ie_mtie <= csr_wdata[7];
                  ie_meie <= csr_wdata[11];
               end
               A_MTVEC:  mtvec  <= csr_wdata;
               A_MEPC:   mepc   <= {csr_wdata[31:2], 2'b00};
               A_MCAUSE: mcause <= csr_wdata;
               default: ;
            endcase
         end
         // Placed after the write so mret's mstatus update takes precedence.
         if (mret_go) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
         end
      end
   end

   // ---------------- cycle counter ----------------
   // A write to either half suppresses the increment for that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mcycle <= 64'd0;
      else if (wr_go && csr_addr == A_MCYCLE)
         mcycle[31:0] <= csr_wdata;
      else if (wr_go && csr_addr == A_MCYCLEH)
         mcycle[63:32] <= csr_wdata;
      else
         mcycle <= mcycle + 64'd1;
   end

endmodule
